// File: rtl/pistorm_bus_arbiter.sv
// 68000 bus arbiter between the Pi-side bus-cycle engine and external masters.
// Runs on PI_CLK and treats the 68K clock and bus-control lines as synchronised data.
module pistorm_bus_arbiter #(
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned BR_FILTER      = 2,
    parameter int unsigned RELEASE_CYCLES = 1,
    parameter int unsigned GRANT_TIMEOUT  = 16
) (
    input  logic       PI_CLK,
    input  logic       RESET_SYNC,
    input  logic       M68K_CLK,
    input  logic       M68K_BR_n,
    input  logic       M68K_BGACK_n,
    input  logic       M68K_AS_n,
    input  logic       ENG_IDLE,
    input  logic       ENG_LATE,
    output logic       M68K_BG_n,
    output logic       ENG_ENABLE,
    output logic       BUS_DRIVE_EN,
    output logic [2:0] ARB_STATE,
    output logic       GRANT_ABORT
);

    localparam int unsigned BR_W  = $clog2(BR_FILTER + 1);
    localparam int unsigned GNT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_OWN   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GRANT = 3'd2,
        ST_EXT   = 3'd3,
        ST_REL   = 3'd4
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] br_sync;
    logic [SYNC_STAGES-1:0] bgack_sync;
    logic [SYNC_STAGES-1:0] as_sync;
    logic                   clk_prev;
    logic [BR_W-1:0]        br_cnt;
    logic [GNT_W-1:0]       gnt_cnt;
    logic [REL_W-1:0]       rel_cnt;

    logic clk_s;
    logic br_s;
    logic bgack_s;
    logic as_s;
    logic c8m_rise;
    logic c8m_fall;
    logic br_req;
    logic grant_ok;

    // Synchronisers preset high so reset never fakes a request or a clock edge.
    always_ff @(posedge PI_CLK) begin
        if (RESET_SYNC) begin
            clk_sync   <= '1;
            br_sync    <= '1;
            bgack_sync <= '1;
            as_sync    <= '1;
            clk_prev   <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], M68K_CLK};
            br_sync    <= {br_sync[SYNC_STAGES-2:0], M68K_BR_n};
            bgack_sync <= {bgack_sync[SYNC_STAGES-2:0], M68K_BGACK_n};
            as_sync    <= {as_sync[SYNC_STAGES-2:0], M68K_AS_n};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign br_s     = br_sync[SYNC_STAGES-1];
    assign bgack_s  = bgack_sync[SYNC_STAGES-1];
    assign as_s     = as_sync[SYNC_STAGES-1];
    assign c8m_rise = clk_s & ~clk_prev;
    assign c8m_fall = ~clk_s & clk_prev;

    // BR_n must stay low across BR_FILTER consecutive 68K rising edges.
    always_ff @(posedge PI_CLK) begin
        if (RESET_SYNC) begin
            br_cnt <= '0;
        end else if (c8m_rise) begin
            if (br_s) begin
                br_cnt <= '0;
            end else if (br_cnt != BR_W'(BR_FILTER)) begin
                br_cnt <= br_cnt + BR_W'(1);
            end
        end
    end

    assign br_req   = (br_cnt == BR_W'(BR_FILTER));
    // Grant either between engine cycles or inside a late cycle that still holds AS.
    assign grant_ok = c8m_fall & (ENG_IDLE | (ENG_LATE & ~as_s));

    always_ff @(posedge PI_CLK) begin
        if (RESET_SYNC) begin
            state        <= ST_OWN;
            M68K_BG_n    <= 1'b1;
            ENG_ENABLE   <= 1'b1;
            BUS_DRIVE_EN <= 1'b1;
            GRANT_ABORT  <= 1'b0;
            gnt_cnt      <= '0;
            rel_cnt      <= '0;
        end else begin
            GRANT_ABORT <= 1'b0;
            case (state)
                ST_OWN: begin
                    if (!bgack_s) begin
                        state        <= ST_EXT;
                        ENG_ENABLE   <= 1'b0;
                        BUS_DRIVE_EN <= 1'b0;
                    end else if (br_req) begin
                        state      <= ST_WAIT;
                        ENG_ENABLE <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!bgack_s) begin
                        state        <= ST_EXT;
                        BUS_DRIVE_EN <= 1'b0;
                    end else if (grant_ok) begin
                        state     <= ST_GRANT;
                        M68K_BG_n <= 1'b0;
                        gnt_cnt   <= '0;
                    end else if (!br_req) begin
                        state      <= ST_OWN;
                        ENG_ENABLE <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!bgack_s && as_s && ENG_IDLE) begin
                        state        <= ST_EXT;
                        M68K_BG_n    <= 1'b1;
                        BUS_DRIVE_EN <= 1'b0;
                    end else if (c8m_fall) begin
                        if ((br_s && bgack_s) || (gnt_cnt == GNT_W'(GRANT_TIMEOUT - 1))) begin
                            state       <= ST_OWN;
                            M68K_BG_n   <= 1'b1;
                            ENG_ENABLE  <= 1'b1;
                            GRANT_ABORT <= 1'b1;
                        end else begin
                            gnt_cnt <= gnt_cnt + GNT_W'(1);
                        end
                    end
                end
                ST_EXT: begin
                    if (bgack_s) begin
                        state   <= ST_REL;
                        rel_cnt <= '0;
                    end
                end
                ST_REL: begin
                    if (!bgack_s) begin
                        state <= ST_EXT;
                    end else if (c8m_fall) begin
                        if (rel_cnt == REL_W'(RELEASE_CYCLES - 1)) begin
                            state        <= ST_OWN;
                            ENG_ENABLE   <= 1'b1;
                            BUS_DRIVE_EN <= 1'b1;
                        end else begin
                            rel_cnt <= rel_cnt + REL_W'(1);
                        end
                    end
                end
                default: begin
                    state        <= ST_OWN;
                    M68K_BG_n    <= 1'b1;
                    ENG_ENABLE   <= 1'b1;
                    BUS_DRIVE_EN <= 1'b1;
                end
            endcase
        end
    end

    assign ARB_STATE = state;

endmodule

// File: tb/tb_pistorm_bus_arbiter.sv
// Scoreboard bench for pistorm_bus_arbiter: a behavioural model predicts every PI_CLK's
// outputs into a queue, and a monitor compares them against the DUT on the falling edge.
module tb_pistorm_bus_arbiter;

    localparam int SYNC_STAGES    = 3;
    localparam int BR_FILTER      = 2;
    localparam int RELEASE_CYCLES = 1;
    localparam int GRANT_TIMEOUT  = 16;

    localparam int M_OWN = 0, M_WAIT = 1, M_GRANT = 2, M_EXT = 3, M_REL = 4;

    logic       PI_CLK = 1'b0;
    logic       RESET_SYNC, M68K_CLK, M68K_BR_n, M68K_BGACK_n, M68K_AS_n;
    logic       ENG_IDLE, ENG_LATE;
    logic       M68K_BG_n, ENG_ENABLE, BUS_DRIVE_EN, GRANT_ABORT;
    logic [2:0] ARB_STATE;

    int n_checks = 0;
    int n_errors = 0;

    pistorm_bus_arbiter #(
        .SYNC_STAGES(SYNC_STAGES), .BR_FILTER(BR_FILTER),
        .RELEASE_CYCLES(RELEASE_CYCLES), .GRANT_TIMEOUT(GRANT_TIMEOUT)
    ) dut (
        .PI_CLK(PI_CLK), .RESET_SYNC(RESET_SYNC), .M68K_CLK(M68K_CLK),
        .M68K_BR_n(M68K_BR_n), .M68K_BGACK_n(M68K_BGACK_n), .M68K_AS_n(M68K_AS_n),
        .ENG_IDLE(ENG_IDLE), .ENG_LATE(ENG_LATE), .M68K_BG_n(M68K_BG_n),
        .ENG_ENABLE(ENG_ENABLE), .BUS_DRIVE_EN(BUS_DRIVE_EN),
        .ARB_STATE(ARB_STATE), .GRANT_ABORT(GRANT_ABORT)
    );

    always #5 PI_CLK = ~PI_CLK;

    // 68K clock: half period of 3..5 PI_CLKs, changed away from the sampling edge.
    initial begin
        M68K_CLK = 1'b1;
        forever begin
            repeat ($urandom_range(5, 3)) @(negedge PI_CLK);
            M68K_CLK = ~M68K_CLK;
        end
    end

    // ---------------- reference model ----------------
    logic [6:0] exp_q[$];
    logic [3:0] hist[$];   // raw {clk,br,bgack,as} samples, oldest first
    int  m_state, m_brc, m_gc, m_rc;
    bit  m_abort, m_valid = 0;

    task automatic model_step();
        logic [3:0] seen;
        bit rise, fall, br_low, bgack_low, as_low, req;
        if (RESET_SYNC) begin
            hist.delete();
            repeat (SYNC_STAGES + 1) hist.push_back(4'hF);
            m_state = M_OWN; m_brc = 0; m_gc = 0; m_rc = 0; m_abort = 0; m_valid = 1;
        end else begin
            // a raw sample becomes usable SYNC_STAGES edges after it was taken
            seen      = hist[1];
            rise      = seen[3] && !hist[0][3];
            fall      = !seen[3] && hist[0][3];
            br_low    = !seen[2];
            bgack_low = !seen[1];
            as_low    = !seen[0];
            hist.push_back({M68K_CLK, M68K_BR_n, M68K_BGACK_n, M68K_AS_n});
            void'(hist.pop_front());
            req     = (m_brc == BR_FILTER);
            m_abort = 0;
            if (rise) m_brc = br_low ? ((m_brc < BR_FILTER) ? m_brc + 1 : BR_FILTER) : 0;
            case (m_state)
                M_OWN:   if (bgack_low) m_state = M_EXT;
                         else if (req) m_state = M_WAIT;
                M_WAIT:  if (bgack_low) m_state = M_EXT;
                         else if (fall && (ENG_IDLE || (ENG_LATE && as_low))) begin
                             m_state = M_GRANT; m_gc = 0;
                         end else if (!req) m_state = M_OWN;
                M_GRANT: if (bgack_low && !as_low && ENG_IDLE) m_state = M_EXT;
                         else if (fall) begin
                             m_gc++;
                             if ((!br_low && !bgack_low) || m_gc == GRANT_TIMEOUT) begin
                                 m_state = M_OWN; m_abort = 1;
                             end
                         end
                M_EXT:   if (!bgack_low) begin m_state = M_REL; m_rc = 0; end
                default: if (bgack_low) m_state = M_EXT;
                         else if (fall) begin
                             m_rc++;
                             if (m_rc == RELEASE_CYCLES) m_state = M_OWN;
                         end
            endcase
        end
        if (m_valid)
            exp_q.push_back({m_state != M_GRANT, m_state == M_OWN,
                             m_state == M_OWN || m_state == M_WAIT || m_state == M_GRANT,
                             3'(m_state), m_abort});
    endtask

    initial forever begin
        @(posedge PI_CLK);
        model_step();
    end

    // ---------------- monitor ----------------
    initial begin
        logic [6:0] e, got;
        forever begin
            @(negedge PI_CLK);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {M68K_BG_n, ENG_ENABLE, BUS_DRIVE_EN, ARB_STATE, GRANT_ABORT};
                n_checks++;
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL outputs t=%0t: got bg_n=%b en=%b drv=%b state=%0d abort=%b, want bg_n=%b en=%b drv=%b state=%0d abort=%b",
                             $time, got[6], got[5], got[4], got[3:1], got[0],
                             e[6], e[5], e[4], e[3:1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge PI_CLK);
    endtask

    task automatic wait_out(input int sel, input logic want, input int budget, input string tag);
        logic v;
        bit hit;
        hit = 0;
        v   = 1'bx;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge PI_CLK);
            case (sel)
                0:       v = M68K_BG_n;
                1:       v = BUS_DRIVE_EN;
                default: v = GRANT_ABORT;
            endcase
            if (v === want) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL %s: output is %b after %0d cycles, required %b", tag, v, budget, want);
        end
    endtask

    task automatic pulse_reset();
        RESET_SYNC = 1'b1;
        cyc(1);
        RESET_SYNC = 1'b0;
    endtask

    initial begin
        RESET_SYNC = 1'b1; M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1; M68K_AS_n = 1'b1;
        ENG_IDLE = 1'b1; ENG_LATE = 1'b0;
        cyc(3);
        RESET_SYNC = 1'b0;
        cyc(20);

        // idle grant, then BGACK takes the bus within SYNC_STAGES+1 clocks
        M68K_BR_n = 1'b0;
        wait_out(0, 1'b0, 200, "idle_grant_bg");
        M68K_BGACK_n = 1'b0; M68K_BR_n = 1'b1;
        wait_out(1, 1'b0, SYNC_STAGES + 1, "idle_grant_tristate");
        cyc(15);
        M68K_BGACK_n = 1'b1;
        wait_out(1, 1'b1, 60, "release_drive");
        cyc(20);

        // in-cycle grant: no EXT until AS is seen high
        ENG_IDLE = 1'b0; ENG_LATE = 1'b1; M68K_AS_n = 1'b0; M68K_BR_n = 1'b0;
        wait_out(0, 1'b0, 200, "in_cycle_grant_bg");
        M68K_BGACK_n = 1'b0; M68K_BR_n = 1'b1;
        cyc(12);
        M68K_AS_n = 1'b1; ENG_IDLE = 1'b1; ENG_LATE = 1'b0;
        wait_out(1, 1'b0, SYNC_STAGES + 1, "in_cycle_ext");
        cyc(10);
        M68K_BGACK_n = 1'b1;
        wait_out(1, 1'b1, 60, "in_cycle_release");
        cyc(20);

        // timeout: BR held, BGACK never comes
        M68K_BR_n = 1'b0;
        wait_out(0, 1'b0, 200, "timeout_grant_bg");
        wait_out(2, 1'b1, 400, "timeout_abort");
        cyc(30);
        M68K_BR_n = 1'b1;
        cyc(80);

        // glitch: BR low across exactly one 68K rising edge
        for (int k = 0; k < 3; k++) begin
            @(negedge M68K_CLK);
            M68K_BR_n = 1'b0;
            @(posedge M68K_CLK);
            @(negedge M68K_CLK);
            M68K_BR_n = 1'b1;
            cyc(30);
        end

        // reset while in GRANT
        M68K_BR_n = 1'b0;
        wait_out(0, 1'b0, 200, "reset_grant_bg");
        cyc(2);
        M68K_BR_n = 1'b1;
        pulse_reset();
        cyc(20);

        // reset while in EXT
        M68K_BR_n = 1'b0;
        wait_out(0, 1'b0, 200, "reset_ext_bg");
        M68K_BGACK_n = 1'b0;
        wait_out(1, 1'b0, SYNC_STAGES + 1, "reset_ext_tristate");
        cyc(5);
        M68K_BGACK_n = 1'b1; M68K_BR_n = 1'b1;
        pulse_reset();
        cyc(20);

        // hidden master: BGACK without any request
        M68K_BGACK_n = 1'b0;
        wait_out(1, 1'b0, SYNC_STAGES + 1, "hidden_master_tristate");
        cyc(10);
        M68K_BGACK_n = 1'b1;
        wait_out(1, 1'b1, 60, "hidden_master_release");
        cyc(10);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge PI_CLK);
            if ($urandom_range(19, 0) == 0) M68K_BR_n    = ~M68K_BR_n;
            if ($urandom_range(29, 0) == 0) M68K_BGACK_n = ~M68K_BGACK_n;
            if ($urandom_range(7, 0) == 0)  M68K_AS_n    = ~M68K_AS_n;
            if ($urandom_range(5, 0) == 0)  ENG_IDLE     = 1'($urandom_range(1, 0));
            if ($urandom_range(5, 0) == 0)  ENG_LATE     = 1'($urandom_range(1, 0));
            RESET_SYNC = ($urandom_range(599, 0) == 0);
        end
        RESET_SYNC = 1'b0; M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1; M68K_AS_n = 1'b1;
        ENG_IDLE = 1'b1; ENG_LATE = 1'b0;
        cyc(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
